param_delay_line: RTL
=====================

// Module: param_delay_line
// PURPOSE
//   Parametrised, tap-selectable shift-register delay line with per-stage valid tracking.
//   Delays a WIDTH-bit data word by a runtime-selected 1..DEPTH clock cycles.
//   Supports a stall enable and a synchronous flush, and reports pipeline occupancy.
//   Sits between a producer and consumer that need a programmable, cycle-exact alignment delay.
// PARAMETERS
//   WIDTH  8  data word width in bits (>=1)
//   DEPTH  8  number of register stages, i.e. maximum delay in cycles (>=2)
//   SEL_W  $clog2(DEPTH)  width of sel; derived, never overridden
//   CNT_W  $clog2(DEPTH+1)  width of occupancy count; derived, never overridden
// PORTS
//   clk        in   1       rising-edge clock; the block's only clock
//   reset      in   1       asynchronous, active-high reset
//   en         in   1       shift enable; 0 = all stages hold
//   flush      in   1       synchronous clear of all stage valid bits and data
//   sel        in   SEL_W   tap select; delay = sel+1 cycles (clamped, see below)
//   in_valid   in   1       input word qualifier
//   in_data    in   WIDTH   input word
//   out_valid  out  1       valid bit of selected tap stage
//   out_data   out  WIDTH   data of selected tap stage
//   occupancy  out  CNT_W   number of stages 0..DEPTH-1 whose valid bit is set
// BEHAVIOUR
// - Storage: stages s[0..DEPTH-1], each {v, d}; all non-blocking updates on posedge clk.
// - Reset (async, reset=1): all v=0, all d=0 immediately; out_valid=0, out_data=0, occupancy=0.
// - Priority per edge: reset > flush > en > hold.
// - flush=1: all v<=0, d<=0 at the edge regardless of en; in_valid/in_data that cycle are dropped.
// - en=1, flush=0: s[0]<={in_valid,in_data}; s[i]<=s[i-1] for i=1..DEPTH-1; s[DEPTH-1] old contents discarded.
// - en=0, flush=0: every stage holds; in_valid/in_data ignored (not buffered).
// - Bubbles: in_valid=0 with en=1 shifts in v=0; d is still captured but is don't-care while v=0.
// - Tap: eff_sel = (sel > DEPTH-1) ? DEPTH-1 : sel (clamp applies only when DEPTH is not a power of 2).
// - Output: out_valid/out_data = s[eff_sel]; combinational mux from registers, no extra register.
// - Latency: with en held high, a word presented at edge N appears on out_* after edge N+eff_sel (delay eff_sel+1 edges, counted from capture into s[0]).
// - en low for k cycles stretches latency by exactly k cycles; no word is lost or duplicated.
// - sel change: takes effect the same cycle (no pipelining of sel). Decreasing sel skips words held in deeper stages;
//   increasing sel re-presents words already output. This behaviour is required, not a bug; consumers change sel only when drained.
// - occupancy: registered popcount of next-state v bits; updates on the same edge as the stages; 0..DEPTH.
// - flush+en same edge: flush wins, occupancy<=0.
// - Reset mid-stream: all in-flight words are discarded; first post-reset word follows normal latency.
// - No combinational path from in_* to out_*.
// TESTING
// 1 Reset: reset=1 mid-stream with stages full -> out_valid=0, out_data=0, occupancy=0 immediately, before next clk edge.
// 2 Latency sweep: DEPTH=8, en=1, sel=0..7; send 0xA5 one cycle -> out_valid=1 with out_data=0xA5 exactly sel+1 edges later, for 1 cycle.
// 3 Stall: sel=3, stream 0x01..0x06 back-to-back, en=0 for 2 cycles mid-stream -> output 0x01..0x06 in order, gap of 2 cycles, no repeats.
// 4 Bubbles/occupancy: pattern in_valid=1,0,1,1 (data 0x11,-,0x22,0x33) with en=1 -> occupancy 1,1,2,3; out_valid mirrors pattern at tap.
// 5 Flush: fill 8 words, assert flush with en=1, in_valid=1, in_data=0xFF -> next cycle occupancy=0, out_valid=0; 0xFF never appears.
// 6 Clamp/sel change: DEPTH=6, sel=7 -> delay 6; switching sel 5->1 with full line -> out_data jumps to s[1] the same cycle.

Source files
------------

// File: rtl/param_delay_line.sv
// param_delay_line: tap-selectable shift-register delay line.
// A WIDTH-bit word (with its valid bit) moves one stage per enabled clock
// through DEPTH stages; the output is a combinational mux of the stage picked
// by sel, giving a programmable delay of sel+1 cycles.
//
// Interface protocol: in_valid/out_valid are pure qualifiers with no
// backpressure. A word is accepted into stage 0 on every rising edge where
// en=1 and flush=0, whether or not in_valid is set; in_valid=0 inserts a bubble.
// en=0 freezes every stage (input ignored, output held); flush clears every
// stage. out_valid/out_data show the selected stage and leave it on the next
// edge that has en=1.
module param_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int SEL_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  // Stage storage: v[i]/d[i] form stage i; stage 0 is the input end.
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  // Next-state values and their valid-bit popcount.
  logic [DEPTH-1:0] v_nxt;
  logic [WIDTH-1:0] d_nxt [DEPTH];
  logic [CNT_W-1:0] cnt_nxt;
  logic [SEL_W-1:0] eff_sel;

  // Next-state: flush beats shift, shift beats hold.
  always_comb begin
    v_nxt = v;
    d_nxt = d;
    if (flush) begin
      v_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_nxt[i] = '0;
      end
    end else if (en) begin
      v_nxt    = {v[DEPTH-2:0], in_valid};
      d_nxt[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        d_nxt[i] = d[i-1];
      end
    end
  end

  // Count next-state valid bits so occupancy lands on the same edge as the stages.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(v_nxt[i]);
    end
  end

  // Stage and occupancy registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else begin
      v         <= v_nxt;
      occupancy <= cnt_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= d_nxt[i];
      end
    end
  end

  // Tap clamp exists only when sel can encode a stage beyond the last one.
  if ((1 << SEL_W) > DEPTH) begin : g_clamp
    // Clamp out-of-range selects to the deepest stage.
    always_comb begin
      eff_sel = (sel > SEL_W'(DEPTH - 1)) ? SEL_W'(DEPTH - 1) : sel;
    end
  end else begin : g_noclamp
    // Every sel value names a real stage.
    always_comb begin
      eff_sel = sel;
    end
  end

  // Output tap: straight mux from stage registers, no extra pipeline.
  always_comb begin
    out_valid = v[eff_sel];
    out_data  = d[eff_sel];
  end

endmodule
